// File: rtl/exp_gate_3_pkg.sv
// exp_gate_3_pkg: shared types and constants for the EXP_GATE_3 share feeder
//   state_t        : feeder FSM states
//   LFSR_TAPS      : taps s[31], s[21], s[1], s[0] of the 32-bit Fibonacci LFSR
//   ADV_STEPS      : LFSR steps per advance (10 mask bits + 9 refresh bits)
//   MASK_*/RND_*   : bit slices of the advanced state used as masks / refresh bits
//   op_idx_t       : operand bit positions, A=0 ... J=9
package exp_gate_3_pkg;
    typedef enum logic [1:0] {ST_UNSEEDED, ST_WARMUP, ST_RUN} state_t;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam int ADV_STEPS = 19;
    localparam int MASK_LO = 0;
    localparam int MASK_HI = 9;
    localparam int RND_LO = 10;
    localparam int RND_HI = 18;
    typedef enum int {OP_A, OP_B, OP_C, OP_D, OP_E, OP_F, OP_G, OP_H, OP_I, OP_J} op_idx_t;
endpackage

// File: rtl/exp_gate_3_lfsr_adv.sv
// exp_gate_3_lfsr_adv: combinational 19-step advance of the 32-bit Fibonacci LFSR
//   s_in  : current LFSR state
//   s_out : state after ADV_STEPS shifts toward the MSB
module exp_gate_3_lfsr_adv
    import exp_gate_3_pkg::*;
(
    input  logic [31:0] s_in,
    output logic [31:0] s_out
);
    always_comb begin
        s_out = s_in;
        for (int i = 0; i < ADV_STEPS; i++) s_out = {s_out[30:0], ^(s_out & LFSR_TAPS)};
    end
endmodule

// File: rtl/exp_gate_3_share_feeder.sv
// exp_gate_3_share_feeder: splits unmasked operands into two Boolean shares and
// supplies fresh refresh bits for the masked EXP_GATE_3 netlist.
//   clk, rst_n             : clock, asynchronous active-low reset
//   seed_valid, seed       : LFSR seed load (all-zero seed becomes 1)
//   in_valid/in_ready      : operand handshake, in_data bit0=A ... bit9=J
//   out_valid/out_ready    : output handshake
//   out_share0/out_share1  : share 0 / share 1 per operand
//   out_r                  : refresh bits r0..r8
//   rng_ok                 : LFSR warmed up, feeder in RUN
// Option: define EXP_GATE_3_FEED_REFRESH_EN to advance the LFSR on every
// non-accept cycle in RUN as well.
module exp_gate_3_share_feeder
    import exp_gate_3_pkg::*;
#(
    parameter int WARMUP_CYCLES = 4,
    parameter int LFSR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                seed_valid,
    input  logic [31:0]         seed,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_J:OP_A]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_J:OP_A]    out_share0,
    output logic [OP_J:OP_A]    out_share1,
    output logic [8:0]          out_r,
    output logic                rng_ok
);
    localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYCLES - 1);
    state_t            state;
    logic [7:0]        wcnt;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic              accept;
    exp_gate_3_lfsr_adv u_adv (.s_in(lfsr), .s_out(lfsr_nxt));
    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign rng_ok   = (state == ST_RUN);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_UNSEEDED;
            wcnt       <= '0;
            lfsr       <= 32'h1;
            out_valid  <= 1'b0;
            out_share0 <= '0;
            out_share1 <= '0;
            out_r      <= '0;
        end else if (seed_valid) begin
            // seed load wins over any handshake and drops the pending output
            lfsr      <= (seed == '0) ? 32'h1 : seed;
            wcnt      <= '0;
            out_valid <= 1'b0;
            state     <= ST_WARMUP;
        end else begin
            case (state)
                ST_WARMUP: begin
                    lfsr  <= lfsr_nxt;
                    wcnt  <= wcnt + 8'd1;
                    state <= (wcnt == WARM_LAST) ? ST_RUN : ST_WARMUP;
                end
                ST_RUN: begin
                    if (accept) begin
                        lfsr       <= lfsr_nxt;
                        out_share1 <= lfsr_nxt[MASK_HI:MASK_LO];
                        out_share0 <= in_data ^ lfsr_nxt[MASK_HI:MASK_LO];
                        out_r      <= lfsr_nxt[RND_HI:RND_LO];
                        out_valid  <= 1'b1;
                    end else begin
                        if (out_ready) out_valid <= 1'b0;
`ifdef EXP_GATE_3_FEED_REFRESH_EN
                        lfsr <= lfsr_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exp_gate_3_share_feeder.sv
// tb_exp_gate_3_share_feeder: table vectors plus random streams checked against a bit-stream LFSR model
module tb_exp_gate_3_share_feeder;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seed_valid = 1'b0;
    logic [31:0] seed = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_share0, out_share1;
    logic [8:0]  out_r;
    logic        rng_ok;

    always #5 clk = ~clk;

    exp_gate_3_share_feeder #(.WARMUP_CYCLES(W), .LFSR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_share0(out_share0), .out_share1(out_share1), .out_r(out_r),
        .rng_ok(rng_ok)
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the LFSR is an infinite bit sequence with recurrence
    // b[n] = b[n-1]^b[n-2]^b[n-22]^b[n-32]; state bit k is the k-th newest bit.
    bit         bs[$];
    int         m_wc;
    bit         m_run, m_ov;
    logic [9:0] m_s0, m_s1;
    logic [8:0] m_r;

    function automatic bit sbit(int k);
        return bs[bs.size() - 1 - k];
    endfunction

    function automatic void m_adv();
        repeat (19) bs.push_back(sbit(0) ^ sbit(1) ^ sbit(21) ^ sbit(31));
        while (bs.size() > 64) void'(bs.pop_front());
    endfunction

    function automatic void m_load(input logic [31:0] v);
        logic [31:0] x;
        x = (v == 0) ? 32'h1 : v;
        bs.delete();
        for (int i = 0; i < 32; i++) bs.push_back(x[31 - i]);
    endfunction

    function automatic logic [9:0] m_mask();
        logic [9:0] m;
        for (int k = 0; k < 10; k++) m[k] = sbit(k);
        return m;
    endfunction

    function automatic logic [8:0] m_rnd();
        logic [8:0] r;
        for (int k = 0; k < 9; k++) r[k] = sbit(10 + k);
        return r;
    endfunction

    function automatic void m_reset();
        m_load(32'h1);
        m_wc = 0; m_run = 0; m_ov = 0;
        m_s0 = '0; m_s1 = '0; m_r = '0;
    endfunction

    // One clock cycle: called #1 after a rising edge, returns #1 after the next one.
    task automatic tick(input bit sv, input logic [31:0] sd, input bit iv, input logic [9:0] d, input bit ordy);
        bit rdy;
        seed_valid = sv; seed = sd; in_valid = iv; in_data = d; out_ready = ordy;
        #2;
        rdy = m_run && (!m_ov || ordy);
        chk("in_ready", in_ready, rdy);
        @(posedge clk); #1;
        if (sv) begin
            m_load(sd); m_wc = W; m_ov = 0; m_run = 0;
        end else if (m_wc > 0) begin
            m_adv(); m_wc--; m_run = (m_wc == 0);
        end else if (m_run) begin
            if (iv && rdy) begin
                m_adv(); m_s1 = m_mask(); m_s0 = d ^ m_s1; m_r = m_rnd(); m_ov = 1;
            end else if (ordy) m_ov = 0;
        end
        chk("out_valid", out_valid, m_ov);
        chk("out_share0", out_share0, m_s0);
        chk("out_share1", out_share1, m_s1);
        chk("out_r", out_r, m_r);
        chk("rng_ok", rng_ok, m_run);
    endtask

    task automatic seed_and_warm(input logic [31:0] sd);
        tick(1, sd, 0, '0, 0);
        repeat (W) tick(0, '0, 0, '0, 0);
    endtask

    typedef struct {
        bit         iv;
        logic [9:0] d;
        bit         ordy;
        bit         exp_ov;
        logic [9:0] exp_x;
    } vec_t;

    vec_t       tv[6];
    logic [9:0] rec_s0[5], rec_s1[5], rec_d[5];
    logic [8:0] rec_r[5];
    logic [9:0] h_s0, h_s1;
    logic [8:0] h_r;
    logic [18:0] prev_pair;
    logic [9:0] d;

    initial begin
        tv[0] = '{1, 10'h3FF, 1, 1, 10'h3FF};
        tv[1] = '{1, 10'h000, 1, 1, 10'h000};
        tv[2] = '{1, 10'h155, 0, 1, 10'h000};
        tv[3] = '{0, 10'h2AA, 1, 0, 10'h000};
        tv[4] = '{1, 10'h2AA, 0, 1, 10'h2AA};
        tv[5] = '{0, 10'h111, 0, 1, 10'h2AA};

        // reset state
        m_reset();
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_share0", out_share0, 0);
        chk("rst_share1", out_share1, 0);
        chk("rst_r", out_r, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rng_ok", rng_ok, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (2) tick(0, '0, 1, 10'h3FF, 1);

        // zero seed: warmup window, then RUN
        tick(1, 32'h0, 1, '0, 1);
        for (int i = 0; i < W; i++) begin
            tick(0, '0, 1, '0, 1);
        end
        #2 out_ready = 1'b1; in_valid = 1'b0;
        #1 chk("rng_ok_up", rng_ok, 1);
        chk("in_ready_up", in_ready, 1);
        @(posedge clk); #1;

        // table vectors
        for (int i = 0; i < 6; i++) begin
            tick(0, '0, tv[i].iv, tv[i].d, tv[i].ordy);
            chk($sformatf("tv%0d_ov", i), out_valid, tv[i].exp_ov);
            chk($sformatf("tv%0d_xor", i), out_share0 ^ out_share1, tv[i].exp_x);
        end

        // random stream, full throughput
        seed_and_warm(32'hACE1_2345);
        for (int i = 0; i < 100; i++) begin
            d = 10'($urandom);
            tick(0, '0, 1, d, 1);
            chk("stream_ov", out_valid, 1);
            chk("stream_xor", out_share0 ^ out_share1, d);
        end

        // backpressure
        tick(0, '0, 1, 10'h1C3, 1);
        h_s0 = out_share0; h_s1 = out_share1; h_r = out_r;
        for (int i = 0; i < 5; i++) begin
            tick(0, '0, 1, 10'($urandom), 0);
            chk("bp_hold", {out_share0, out_share1, out_r}, {h_s0, h_s1, h_r});
            chk("bp_ov", out_valid, 1);
        end
        tick(0, '0, 1, 10'h0F0, 1);
        chk("bp_release_xor", out_share0 ^ out_share1, 10'h0F0);

        // mid-stream reseed restarts the sequence
        seed_and_warm(32'h1357_9BDF);
        for (int i = 0; i < 5; i++) begin
            rec_d[i] = 10'($urandom);
            tick(0, '0, 1, rec_d[i], 1);
            rec_s0[i] = out_share0; rec_s1[i] = out_share1; rec_r[i] = out_r;
        end
        tick(1, 32'h1357_9BDF, 1, 10'h3FF, 1);
        chk("reseed_ov_clear", out_valid, 0);
        for (int i = 0; i < W; i++) tick(0, '0, 1, '0, 1);
        for (int i = 0; i < 5; i++) begin
            tick(0, '0, 1, rec_d[i], 1);
            chk("reseed_repeat", {out_share0, out_share1, out_r}, {rec_s0[i], rec_s1[i], rec_r[i]});
        end

        // asynchronous reset mid-stream
        tick(0, '0, 1, 10'h2F5, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", out_valid, 0);
        chk("arst_outs", {out_share0, out_share1, out_r}, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_rng_ok", rng_ok, 0);
        m_reset();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (3) tick(0, '0, 1, 10'h3FF, 1);
        seed_and_warm(32'hDEAD_BEEF);

        // freshness over a long stream
        prev_pair = {out_r, out_share1};
        for (int i = 0; i < 1000; i++) begin
            d = 10'($urandom);
            tick(0, '0, 1, d, 1);
            n_tests++;
            if ({out_r, out_share1} === prev_pair) begin
                n_fail++;
                $display("FAIL fresh: pair %0h repeated at transaction %0d", prev_pair, i);
            end
            prev_pair = {out_r, out_share1};
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
